// File: rtl/aes_dom_mul_seq_ctrl.sv
// Sequencing front-end for the first-order DOM-dep GF(2^N) multiplier: operand/randomness
// staging (S1), multiplier enable, pipelined operand copies (S2) and output backpressure.
module aes_dom_mul_seq_ctrl #(
  parameter int unsigned NPower = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [NPower-1:0]     a_x_i,
  input  logic [NPower-1:0]     b_x_i,
  input  logic [NPower-1:0]     a_y_i,
  input  logic [NPower-1:0]     b_y_i,

  output logic                  prd_req_o,
  input  logic                  prd_ack_i,
  input  logic [2*NPower-1:0]   prd_i,

  output logic                  mul_we_o,
  output logic [NPower-1:0]     mul_a_x_o,
  output logic [NPower-1:0]     mul_b_x_o,
  output logic [NPower-1:0]     mul_a_y_o,
  output logic [NPower-1:0]     mul_b_y_o,
  output logic [NPower-1:0]     mul_a_x_q_o,
  output logic [NPower-1:0]     mul_b_x_q_o,
  output logic [NPower-1:0]     mul_a_y_q_o,
  output logic [NPower-1:0]     mul_b_y_q_o,
  output logic [NPower-1:0]     mul_z0_o,
  output logic [NPower-1:0]     mul_z1_o,
  input  logic [NPower-1:0]     mul_a_q_i,
  input  logic [NPower-1:0]     mul_b_q_i,

  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [NPower-1:0]     out_a_q_o,
  output logic [NPower-1:0]     out_b_q_o
);

  typedef enum logic [1:0] {StIdle, StWaitPrd, StReady} state_e;

  state_e st_q, st_d;

  // S1 operand and randomness registers.
  logic [NPower-1:0] a_x_q, a_x_d, b_x_q, b_x_d, a_y_q, a_y_d, b_y_q, b_y_d;
  logic [NPower-1:0] z0_q, z0_d, z1_q, z1_d;

  // S2 pipelined operand copies, aligned with the multiplier's internal registers.
  logic [NPower-1:0] a_x_s2_q, a_x_s2_d, b_x_s2_q, b_x_s2_d;
  logic [NPower-1:0] a_y_s2_q, a_y_s2_d, b_y_s2_q, b_y_s2_d;
  logic              s2_v_q, s2_v_d;

  logic xfer, accept, prd_take, out_hs;

  assign xfer   = (st_q == StReady) && (!s2_v_q || out_ready_i);
  // Gated by reset so the handshake outputs read 0 while reset is held.
  assign in_ready_o = !rst_i && ((st_q == StIdle) || xfer);
  assign prd_req_o  = !rst_i && (st_q == StWaitPrd);
  assign accept   = in_ready_o && in_valid_i;
  assign prd_take = prd_req_o && prd_ack_i;
  assign out_hs   = s2_v_q && out_ready_i;

  assign mul_we_o    = xfer;
  assign mul_a_x_o   = a_x_q;
  assign mul_b_x_o   = b_x_q;
  assign mul_a_y_o   = a_y_q;
  assign mul_b_y_o   = b_y_q;
  assign mul_a_x_q_o = a_x_s2_q;
  assign mul_b_x_q_o = b_x_s2_q;
  assign mul_a_y_q_o = a_y_s2_q;
  assign mul_b_y_q_o = b_y_s2_q;
  assign mul_z0_o    = z0_q;
  assign mul_z1_o    = z1_q;

  assign out_valid_o = s2_v_q;
  assign out_a_q_o   = mul_a_q_i;
  assign out_b_q_o   = mul_b_q_i;

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle:    if (accept) st_d = StWaitPrd;
      StWaitPrd: if (prd_take) st_d = StReady;
      StReady:   if (xfer) st_d = accept ? StWaitPrd : StIdle;
      default:   st_d = StIdle;
    endcase
  end

  always_comb begin
    a_x_d = a_x_q;
    b_x_d = b_x_q;
    a_y_d = a_y_q;
    b_y_d = b_y_q;
    if (accept) begin
      a_x_d = a_x_i;
      b_x_d = b_x_i;
      a_y_d = a_y_i;
      b_y_d = b_y_i;
    end else if (xfer) begin
      a_x_d = '0;
      b_x_d = '0;
      a_y_d = '0;
      b_y_d = '0;
    end
  end

  // Each randomness pair feeds exactly one enable pulse and is wiped right after.
  always_comb begin
    z0_d = z0_q;
    z1_d = z1_q;
    if (prd_take) begin
      z0_d = prd_i[NPower-1:0];
      z1_d = prd_i[2*NPower-1:NPower];
    end else if (xfer) begin
      z0_d = '0;
      z1_d = '0;
    end
  end

  always_comb begin
    a_x_s2_d = a_x_s2_q;
    b_x_s2_d = b_x_s2_q;
    a_y_s2_d = a_y_s2_q;
    b_y_s2_d = b_y_s2_q;
    s2_v_d   = s2_v_q;
    if (xfer) begin
      a_x_s2_d = a_x_q;
      b_x_s2_d = b_x_q;
      a_y_s2_d = a_y_q;
      b_y_s2_d = b_y_q;
      s2_v_d   = 1'b1;
    end else if (out_hs) begin
      a_x_s2_d = '0;
      b_x_s2_d = '0;
      a_y_s2_d = '0;
      b_y_s2_d = '0;
      s2_v_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q     <= StIdle;
      a_x_q    <= '0;
      b_x_q    <= '0;
      a_y_q    <= '0;
      b_y_q    <= '0;
      z0_q     <= '0;
      z1_q     <= '0;
      a_x_s2_q <= '0;
      b_x_s2_q <= '0;
      a_y_s2_q <= '0;
      b_y_s2_q <= '0;
      s2_v_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      a_x_q    <= a_x_d;
      b_x_q    <= b_x_d;
      a_y_q    <= a_y_d;
      b_y_q    <= b_y_d;
      z0_q     <= z0_d;
      z1_q     <= z1_d;
      a_x_s2_q <= a_x_s2_d;
      b_x_s2_q <= b_x_s2_d;
      a_y_s2_q <= a_y_s2_d;
      b_y_s2_q <= b_y_s2_d;
      s2_v_q   <= s2_v_d;
    end
  end

endmodule

// File: tb/tb_aes_dom_mul_seq_ctrl.sv
// Bench for aes_dom_mul_seq_ctrl: a behavioural DOM multiplier, a transaction scoreboard,
// a table of single operations and directed stall/backpressure/reset/stream sequences.
module tb_aes_dom_mul_seq_ctrl;

  localparam int unsigned NP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, prd_req, prd_ack, mul_we, out_valid, out_ready;
  logic [NP-1:0] a_x, b_x, a_y, b_y;
  logic [2*NP-1:0] prd;
  logic [NP-1:0] m_ax, m_bx, m_ay, m_by, m_axq, m_bxq, m_ayq, m_byq, m_z0, m_z1;
  logic [NP-1:0] mq_a, mq_b, out_a, out_b;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_dom_mul_seq_ctrl #(.NPower(NP)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_x_i(a_x), .b_x_i(b_x), .a_y_i(a_y), .b_y_i(b_y),
    .prd_req_o(prd_req), .prd_ack_i(prd_ack), .prd_i(prd),
    .mul_we_o(mul_we),
    .mul_a_x_o(m_ax), .mul_b_x_o(m_bx), .mul_a_y_o(m_ay), .mul_b_y_o(m_by),
    .mul_a_x_q_o(m_axq), .mul_b_x_q_o(m_bxq), .mul_a_y_q_o(m_ayq), .mul_b_y_q_o(m_byq),
    .mul_z0_o(m_z0), .mul_z1_o(m_z1),
    .mul_a_q_i(mq_a), .mul_b_q_i(mq_b),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_a_q_o(out_a), .out_b_q_o(out_b)
  );

  // GF(2^4) in the normal basis used by the AES S-Box datapath.
  function automatic logic [1:0] gf2(input logic [1:0] g, input logic [1:0] d);
    logic a, b, c;
    a = g[1] & d[1];
    b = (g[1] ^ g[0]) & (d[1] ^ d[0]);
    c = g[0] & d[0];
    return {a ^ b, c ^ b};
  endfunction

  function automatic logic [1:0] sc_w2(input logic [1:0] g);
    return {g[0], g[1] ^ g[0]};
  endfunction

  function automatic logic [3:0] gf4(input logic [3:0] g, input logic [3:0] d);
    logic [1:0] a, b, c;
    a = gf2(g[3:2], d[3:2]);
    b = gf2(g[3:2] ^ g[1:0], d[3:2] ^ d[1:0]);
    c = gf2(g[1:0], d[1:0]);
    return {a ^ sc_w2(b), c ^ sc_w2(b)};
  endfunction

  function automatic logic [3:0] r4();
    logic [31:0] t;
    t = $urandom;
    return t[3:0];
  endfunction

  function automatic logic [7:0] r8();
    logic [31:0] t;
    t = $urandom;
    return t[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural multiplier: result shares XOR to the product, z0 masks the cross terms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mq_a <= '0;
      mq_b <= '0;
    end else if (mul_we) begin
      mq_a <= gf4(m_ax, m_ay) ^ gf4(m_ax, m_by) ^ m_z0;
      mq_b <= gf4(m_bx, m_by) ^ gf4(m_bx, m_ay) ^ m_z0;
    end
  end

  // Transaction scoreboard: accepted sharings, fetched randomness and pending products.
  logic [15:0] q_ops[$];
  logic [7:0]  q_z[$];
  logic [3:0]  q_res[$];
  int          res_cyc[$];
  logic [15:0] s_op;
  logic [7:0]  s_z;
  logic [3:0]  s_e;

  always @(negedge clk) begin
    if (rst) begin
      q_ops.delete();
      q_z.delete();
      q_res.delete();
    end else begin
      if (out_valid && !out_ready) chk("bp_no_we", 32'(mul_we), 32'd0);
      if (out_valid && out_ready) begin
        if (q_res.size() == 0) chk("res_unexpected", 32'd1, 32'd0);
        else begin
          s_e = q_res.pop_front();
          chk("result", 32'(out_a ^ out_b), 32'(s_e));
          res_cyc.push_back(cyc);
        end
      end
      if (mul_we) begin
        if (q_ops.size() == 0 || q_z.size() == 0) chk("we_unexpected", 32'd1, 32'd0);
        else begin
          s_op = q_ops.pop_front();
          s_z  = q_z.pop_front();
          chk("we_ops", 32'({m_ax, m_bx, m_ay, m_by}), 32'(s_op));
          chk("we_z", 32'({m_z1, m_z0}), 32'(s_z));
          q_res.push_back(gf4(s_op[15:12] ^ s_op[11:8], s_op[7:4] ^ s_op[3:0]));
        end
      end
      if (in_valid && in_ready) q_ops.push_back({a_x, b_x, a_y, b_y});
      if (prd_req && prd_ack) q_z.push_back(prd);
    end
  end

  typedef struct packed {
    logic [3:0] ax, bx, ay, by;
    logic [7:0] prd;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [31:0] mul_all();
    return {m_ax, m_bx, m_ay, m_by, m_axq, m_bxq, m_ayq, m_byq};
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [3:0] ax, bx, ay, by);
    a_x = ax; b_x = bx; a_y = ay; b_y = by;
  endtask

  // One operation with immediate ack and a ready sink; starts and ends in IDLE.
  task automatic run_single(input vec_t v);
    drive_op(v.ax, v.bx, v.ay, v.by);
    in_valid = 1'b1; prd_ack = 1'b1; prd = v.prd; out_ready = 1'b1;
    @(negedge clk);
    chk("c0_in_ready", 32'(in_ready), 32'd1);
    chk("c0_we", 32'(mul_we), 32'd0);
    nxt();
    in_valid = 1'b0; drive_op(r4(), r4(), r4(), r4());
    @(negedge clk);
    chk("c1_prd_req", 32'(prd_req), 32'd1);
    chk("c1_in_ready", 32'(in_ready), 32'd0);
    chk("c1_we", 32'(mul_we), 32'd0);
    nxt();
    prd = r8();
    @(negedge clk);
    chk("c2_we", 32'(mul_we), 32'd1);
    chk("c2_z", 32'({m_z1, m_z0}), 32'(v.prd));
    chk("c2_ops", 32'({m_ax, m_bx, m_ay, m_by}), 32'({v.ax, v.bx, v.ay, v.by}));
    chk("c2_in_ready", 32'(in_ready), 32'd1);
    nxt();
    @(negedge clk);
    chk("c3_valid", 32'(out_valid), 32'd1);
    chk("c3_we", 32'(mul_we), 32'd0);
    chk("c3_unmasked", 32'(out_a ^ out_b), 32'(v.exp));
    chk("c3_regs", mul_all(), {16'h0, v.ax, v.bx, v.ay, v.by});
    chk("c3_z_zero", 32'({m_z1, m_z0}), 32'd0);
    nxt();
    @(negedge clk);
    chk("c4_valid", 32'(out_valid), 32'd0);
    chk("c4_zeroized", mul_all(), 32'd0);
    chk("c4_z_zero", 32'({m_z1, m_z0}), 32'd0);
    chk("c4_in_ready", 32'(in_ready), 32'd1);
    nxt();
  endtask

  logic [3:0] hold_a, hold_b;
  int         req_cnt, acc, budget;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{ax: 4'hA, bx: 4'h9, ay: 4'h6, by: 4'h3, prd: 8'h7C, exp: 4'h1};
    tbl[1] = '{ax: 4'h5, bx: 4'h5, ay: 4'hE, by: 4'h2, prd: 8'h3A, exp: 4'h0};
    tbl[2] = '{ax: 4'h4, bx: 4'hB, ay: 4'h9, by: 4'h9, prd: 8'hC1, exp: 4'h0};
    tbl[3] = '{ax: 4'hF, bx: 4'h1, ay: 4'h3, by: 4'h8, prd: 8'h55, exp: gf4(4'hE, 4'hB)};
    tbl[4] = '{ax: 4'h0, bx: 4'h7, ay: 4'h2, by: 4'hC, prd: 8'h0F, exp: gf4(4'h7, 4'hE)};
    tbl[5] = '{ax: 4'h1, bx: 4'h2, ay: 4'h4, by: 4'h8, prd: 8'hA6, exp: gf4(4'h3, 4'hC)};

    rst = 1'b1; in_valid = 1'b0; prd_ack = 1'b0; prd = '0; out_ready = 1'b0;
    drive_op(4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_handshakes", 32'({in_ready, prd_req, mul_we, out_valid}), 32'd0);
    chk("rst_regs", mul_all(), 32'd0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    nxt();

    for (int i = 0; i < 6; i++) run_single(tbl[i]);

    // Spurious randomness in IDLE must not load.
    prd_ack = 1'b1; prd = 8'hFF;
    nxt();
    @(negedge clk);
    chk("idle_ack_z", 32'({m_z1, m_z0}), 32'd0);
    chk("idle_ack_req", 32'(prd_req), 32'd0);
    nxt();

    // Randomness stall of 5 cycles.
    prd_ack = 1'b0; in_valid = 1'b1; out_ready = 1'b1; drive_op(r4(), r4(), r4(), r4());
    @(negedge clk);
    nxt();
    in_valid = 1'b0; req_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (prd_req) req_cnt++;
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_we", 32'(mul_we), 32'd0);
      nxt();
    end
    prd_ack = 1'b1; prd = r8();
    @(negedge clk);
    if (prd_req) req_cnt++;
    chk("stall_we_at_ack", 32'(mul_we), 32'd0);
    nxt();
    prd_ack = 1'b0;
    chk("stall_req_cycles", 32'(req_cnt), 32'd6);
    @(negedge clk);
    chk("stall_we_after", 32'(mul_we), 32'd1);
    chk("stall_req_low", 32'(prd_req), 32'd0);
    nxt();
    @(negedge clk);
    chk("stall_valid", 32'(out_valid), 32'd1);
    nxt();
    nxt();

    // Backpressure: result held in S2 while a second operation waits in READY.
    out_ready = 1'b0; prd_ack = 1'b1; prd = r8(); in_valid = 1'b1;
    drive_op(r4(), r4(), r4(), r4());
    nxt();
    in_valid = 1'b0;
    nxt();
    in_valid = 1'b1; drive_op(r4(), r4(), r4(), r4()); prd = r8();
    @(negedge clk);
    chk("bp_first_xfer", 32'({mul_we, in_ready}), 32'h3);
    nxt();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_c3", 32'({out_valid, prd_req}), 32'h3);
    nxt();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        hold_a = out_a;
        hold_b = out_b;
      end else begin
        chk("bp_hold_a", 32'(out_a), 32'(hold_a));
        chk("bp_hold_b", 32'(out_b), 32'(hold_b));
      end
      chk("bp_stalled", 32'({mul_we, in_ready, out_valid}), 32'h1);
      nxt();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'({mul_we, in_ready, out_valid}), 32'h7);
    nxt();
    @(negedge clk);
    chk("bp_s2v_kept", 32'(out_valid), 32'd1);
    nxt();
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'd0);
    nxt();

    // Back-to-back stream of 8 sharings.
    res_cyc.delete();
    prd_ack = 1'b1; out_ready = 1'b1; in_valid = 1'b1; acc = 0;
    for (budget = 0; budget < 40 && acc < 8; budget++) begin
      drive_op(r4(), r4(), r4(), r4()); prd = r8();
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      nxt();
    end
    in_valid = 1'b0;
    chk("stream_accepts", 32'(acc), 32'd8);
    for (budget = 0; budget < 40 && res_cyc.size() < 8; budget++) nxt();
    chk("stream_results", 32'(res_cyc.size()), 32'd8);
    for (int i = 1; i < res_cyc.size(); i++)
      chk("stream_spacing", 32'(res_cyc[i] - res_cyc[i-1]), 32'd2);
    @(negedge clk);
    chk("final_zero_regs", mul_all(), 32'd0);
    chk("final_zero_z", 32'({m_z1, m_z0}), 32'd0);
    nxt();

    // Randomized ack, ready and valid against the scoreboard.
    acc = 0;
    for (budget = 0; budget < 3000 && acc < 40; budget++) begin
      in_valid = ($urandom_range(0, 1) == 1);
      drive_op(r4(), r4(), r4(), r4());
      prd_ack = ($urandom_range(0, 2) == 0);
      prd = r8();
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      nxt();
    end
    chk("rand_accepts", 32'(acc), 32'd40);
    in_valid = 1'b0; prd_ack = 1'b1; out_ready = 1'b1;
    for (budget = 0; budget < 60 && (q_ops.size() + q_res.size() != 0 || out_valid); budget++)
      nxt();
    chk("rand_drain", 32'(q_ops.size() + q_z.size() + q_res.size()), 32'd0);

    // Reset while waiting for randomness.
    prd_ack = 1'b0; in_valid = 1'b1; drive_op(r4(), r4(), r4(), r4());
    nxt();
    in_valid = 1'b0;
    @(negedge clk);
    chk("rw_prd_req", 32'(prd_req), 32'd1);
    nxt();
    rst = 1'b1;
    #1;
    chk("rw_outputs", 32'({in_ready, prd_req, mul_we, out_valid}), 32'd0);
    chk("rw_regs", mul_all(), 32'd0);
    nxt();
    rst = 1'b0; prd_ack = 1'b1; prd = 8'hFF;
    @(negedge clk);
    chk("rw_release", 32'({in_ready, prd_req}), 32'h2);
    nxt();
    @(negedge clk);
    chk("rw_late_ack_z", 32'({m_z1, m_z0}), 32'd0);
    nxt();

    // Reset while a result is held in S2.
    prd_ack = 1'b1; out_ready = 1'b0; in_valid = 1'b1; prd = r8();
    drive_op(r4(), r4(), r4(), r4());
    nxt();
    in_valid = 1'b0;
    nxt();
    nxt();
    @(negedge clk);
    chk("rs_valid", 32'(out_valid), 32'd1);
    nxt();
    rst = 1'b1;
    #1;
    chk("rs_outputs", 32'({in_ready, prd_req, mul_we, out_valid}), 32'd0);
    chk("rs_regs", mul_all(), 32'd0);
    chk("rs_z", 32'({m_z1, m_z0}), 32'd0);
    nxt();
    rst = 1'b0; out_ready = 1'b1; prd_ack = 1'b0;
    @(negedge clk);
    chk("rs_release", 32'({in_ready, out_valid}), 32'h2);
    nxt();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_dom_mul_seq_ctrl.md
# aes_dom_mul_seq_ctrl

Sequencing front-end for the first-order DOM-dep GF(2^N) multiplier in the masked AES S-Box datapath. It accepts shared operands over a valid/ready handshake and fetches fresh randomness (z_0, z_1) for each operation from the PRD source. It drives the multiplier's live and pipelined operand inputs and its `we_i` strobe, then presents the multiplier's output shares downstream with backpressure. Operand and randomness registers are zeroized once consumed.

## Interface
- `NPower`, 4: GF(2^NPower) field size; only 4 or 2 are legal.
- `clk_i`  in  1  clock
- `rst_i`  in  1  asynchronous, active-high reset
- `in_valid_i`  in  1  operand sharing valid
- `in_ready_o`  out  1  operand accept
- `a_x_i`, `b_x_i`, `a_y_i`, `b_y_i`  in  NPower each  shares of x and y
- `prd_req_o`  out  1  randomness request
- `prd_ack_i`  in  1  randomness valid
- `prd_i`  in  2*NPower  fresh randomness; `[NPower-1:0]` is z_0, upper half is z_1
- `mul_we_o`  out  1  multiplier register enable
- `mul_a_x_o`, `mul_b_x_o`, `mul_a_y_o`, `mul_b_y_o`  out  NPower each  live operand shares (S1)
- `mul_a_x_q_o`, `mul_b_x_q_o`, `mul_a_y_q_o`, `mul_b_y_q_o`  out  NPower each  pipelined operand shares (S2)
- `mul_z0_o`, `mul_z1_o`  out  NPower each  randomness to the multiplier
- `mul_a_q_i`, `mul_b_q_i`  in  NPower each  multiplier output shares
- `out_valid_o`  out  1  result valid
- `out_ready_i`  in  1  result accept
- `out_a_q_o`, `out_b_q_o`  out  NPower each  result shares

## Operation
- Two stages.
  - S1 holds the operands and randomness, under FSM control.
  - S2 is the multiplier's internal registers plus this block's pipelined operand copies; its valid bit is `s2_v`.
- FSM states:
  - IDLE: S1 empty.
  - WAIT_PRD: S1 holds operands; `prd_req_o`=1.
  - READY: S1 holds operands and randomness.
- IDLE: `in_ready_o`=1. On `in_valid_i`, capture the four shares and go to WAIT_PRD.
- WAIT_PRD: `prd_req_o` stays high until `prd_ack_i`. On ack, capture z_0/z_1 and go to READY. `prd_ack_i` in any other state is ignored.
- Transfer condition: `xfer` = READY && (!`s2_v` || `out_ready_i`). On `xfer`:
  - `mul_we_o`=1 (combinational, that cycle only).
  - S1 operands are copied into the S2 `_q` registers.
  - `s2_v` is set to 1.
- In READY, `in_ready_o` = `xfer`.
  - Acceptance in the same cycle: capture new operands and go to WAIT_PRD.
  - No acceptance: go to IDLE.
- Randomness registers are cleared to 0 on every `xfer`. Each z value is used by exactly one `mul_we_o` pulse and is never reused.
- S1 operand registers are cleared to 0 on `xfer` unless new operands are captured in that cycle.
- `out_valid_o` = `s2_v`. `out_a_q_o`/`out_b_q_o` pass through `mul_a_q_i`/`mul_b_q_i` combinationally.
- Output handshake (`out_valid_o && out_ready_i`):
  - Without a simultaneous `xfer`: `s2_v` clears to 0 and the S2 `_q` registers clear to 0.
  - With a simultaneous `xfer`: `s2_v` stays 1.
- While `s2_v`=1 and `out_ready_i`=0, `mul_we_o` stays 0 and the multiplier state is held.
- Shares are never recombined inside the block. No logic combines an `a_*` signal with a `b_*` signal.

## Timing
- Reset values:
  - Every register is 0 and the FSM is in IDLE.
  - `in_ready_o`, `prd_req_o`, `mul_we_o` and `out_valid_o` are all 0 while `rst_i`=1.
  - `in_ready_o`=1 from the first cycle after reset release.
- Reset mid-operation discards S1 and S2 contents immediately. An outstanding request is dropped, and any late `prd_ack_i` after release is ignored in IDLE.
- Latency with immediate ack and `out_ready_i`=1:
  - accept at cycle 0;
  - `prd_req_o` at cycle 1 (ack in the same cycle);
  - `xfer`/`mul_we_o` at cycle 2;
  - `out_valid_o` at cycle 3.
- Peak throughput is one operation per 2 cycles, because accept and `xfer` overlap.
- `prd_i` is sampled only in the cycle where `prd_req_o && prd_ack_i`.

## Test plan
- Single operation: NPower=4, x=0x3 masked with a_x=0xA, b_x=0x9; y=0x5 masked with a_y=0x6, b_y=0x3; randomness 0x7C; `prd_ack_i` tied to 1; `out_ready_i`=1. Required: `mul_we_o` high in cycle 2 only; `out_valid_o` in cycle 3; `out_a_q_o`^`out_b_q_o` equals `aes_mul_gf2p4(0x3,0x5)`.
- Randomness stall: ack delayed 5 cycles. Required: `prd_req_o` high for 6 cycles, `in_ready_o`=0 throughout, no `mul_we_o` before the ack.
- Backpressure: `out_ready_i`=0 for 4 cycles with a second operation in READY. Required: `mul_we_o` stays 0 and the output shares are stable. When ready rises, the output handshake and `xfer` occur in the same cycle and `s2_v` remains 1.
- Back-to-back stream of 8 random sharings, with ack=1 and ready=1. Required: one result every 2 cycles, all unmasked results match the model, and no `prd_i` value is ever used by two `mul_we_o` pulses.
- Zeroization: after the final result is accepted, all `mul_*_o` outputs read 0. A spurious `prd_ack_i`=1 with `prd_i`=0xFF in IDLE leaves `mul_z0_o` and `mul_z1_o` at 0.
- Reset asserted while in WAIT_PRD and again while `s2_v`=1. Required: outputs are 0 the same cycle, and after release the block is in IDLE with `in_ready_o`=1.
